rom_window_fetch: RTL and testbench
===================================

ROM_WINDOW_FETCH -- requirements
Module: rom_window_fetch

Interface
REQ-001 Parameter IMG_W, default 32, image width and height in pixels (square image).
REQ-002 Parameter K, default 5, convolution kernel edge in pixels.
REQ-003 Parameter STRIDE, default 1, window step in pixels, in both x and y.
REQ-004 Parameter FIFO_D, default 4, depth of the output pixel buffer.
REQ-005 clk  in  1  Sole clock; all logic is on the rising edge.
REQ-006 rst  in  1  Reset; synchronous and active-high.
REQ-007 start  in  1  Starts one full-image window scan; sampled only in IDLE.
REQ-008 abort  in  1  Terminates the scan in progress.
REQ-009 busy  out  1  High in any state other than IDLE.
REQ-010 done  out  1  One-cycle pulse at normal scan completion.
REQ-011 rom_aa  out  10  ROM address; registered.
REQ-012 rom_cena  out  1  ROM enable, active-low; registered.
REQ-013 rom_qa  in  `WD  ROM read data; valid one cycle after the edge that samples rom_cena=0.
REQ-014 pix_data  out  `WD  Window pixel.
REQ-015 pix_valid  out  1  pix_data holds a valid pixel.
REQ-016 pix_ready  in  1  Consumer accepts; transfer occurs when pix_valid and pix_ready are both high.
REQ-017 pix_last  out  1  Marks the final pixel (ky=K-1, kx=K-1) of each window.

Function
REQ-018 OUT = (IMG_W-K)/STRIDE+1 (28 at defaults); windows are scanned oy 0..OUT-1 outer, ox inner.
REQ-019 Within each window, pixels are scanned ky outer, kx inner; address = (oy*STRIDE+ky)*IMG_W + ox*STRIDE + kx.
REQ-020 FSM states: IDLE; RUN (issuing reads); DRAIN (all reads issued, buffer not yet empty); DONE (one cycle, done=1, then IDLE).
REQ-021 IDLE->RUN on start=1; start is ignored in any other state.
REQ-022 RUN->DRAIN after the read of the last pixel of window (OUT-1, OUT-1) is issued.
REQ-023 DRAIN->DONE when the buffer is empty, no read is in flight, and the last pixel has been transferred.
REQ-024 One read is issued per cycle (rom_cena=0, rom_aa=addr) only when buffer_count + inflight < FIFO_D; otherwise rom_cena=1.
REQ-025 inflight counts issued reads whose data has not yet been written to the buffer (maximum 2).
REQ-026 Buffer overflow is impossible; a simultaneous push and pop on a full buffer does not occur.
REQ-027 Latency: with pix_ready held high, pix_valid first rises on the 3rd rising edge after the edge that samples start.
REQ-028 Throughput: with pix_ready held high, 1 pixel per cycle is sustained with no bubbles after the first pixel.
REQ-029 While pix_valid=1 and pix_ready=0, pix_data and pix_last hold stable.
REQ-030 pix_last travels through the buffer alongside its pixel.
REQ-031 abort=1 in any state: next state IDLE, buffer and inflight flushed, rom_cena=1, pix_valid=0, and done is not pulsed.
REQ-032 If abort and start are high together in IDLE, abort wins and the block stays in IDLE.
REQ-033 A scan produces exactly OUT*OUT*K*K pixels (19600 at defaults); address arithmetic is unsigned and 10 bits wide, with no wrap.

Reset
REQ-034 rst=1 forces: state=IDLE, busy=0, done=0, rom_cena=1, rom_aa=0, pix_valid=0, pix_last=0, pix_data=0, all counters=0, buffer empty.
REQ-035 rst asserted mid-scan has the same effect as REQ-034 at the next edge; reads in flight are discarded.

Structure
REQ-036 `WD, IMG_W, and K defaults live in the shared global.v include.
REQ-037 The buffer is one sub-module, fetch_fifo: FIFO_D x (`WD+1), synchronous, with count output.
REQ-038 The oy/ox/ky/kx counters and the FSM reside in rom_window_fetch.

Verification
REQ-039 ROM model mem[a]=a[7:0]; start pulse, pix_ready=1 -> first pixel 3 cycles later, data 0x00; 25th pixel has data 0x84 (addr 132) and pix_last=1.
REQ-040 Full scan at pix_ready=1 -> 19600 transfers, 784 pix_last pulses, last addr 1023, done pulse after final transfer, 0 bubbles.
REQ-041 Second window -> first pixel addr 1, last pixel addr 133.
REQ-042 pix_ready random 50% -> data sequence identical to REQ-040, stable under stall, buffer count never exceeds 4.
REQ-043 abort at transfer 100 -> IDLE next cycle, pix_valid=0, no done; a new start restarts at addr 0.
REQ-044 start pulsed while busy -> ignored, scan count unchanged; rst at transfer 50 -> all outputs at REQ-034 values next cycle.

Source files
------------

// File: rtl/rom_window_fetch_pkg.sv
// Shared widths, defaults and FSM encoding for the window fetch block.
// Pixel width and image/kernel defaults live here for all users.
package rom_window_fetch_pkg;

  localparam int WD        = 8;
  localparam int AW        = 10;
  localparam int IMG_W_DEF = 32;
  localparam int K_DEF     = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic int out_dim(
    input int img_w,
    input int k,
    input int stride
  );
    return (img_w - k) / stride + 1;
  endfunction

endpackage

// File: rtl/rom_window_fetch_fifo.sv
// Small synchronous pixel buffer with occupancy count.
// Output reads as zero while empty so idle outputs stay clean.
module fetch_fifo #(
  parameter int DW = 9,
  parameter int D  = 4,
  localparam int PW = (D > 1) ? $clog2(D) : 1,
  localparam int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem_q [D];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop;
  logic          do_push;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(D)) || do_pop);
  assign dout_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push && !(rst || flush_i)) begin
      mem_q[wr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= inc(wr_q);
      if (do_pop)  rd_q <= inc(rd_q);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/rom_window_fetch.sv
// Scans every KxK window of a square ROM image and streams its pixels.
// Reads are throttled so buffered plus in-flight data never exceeds FIFO_D.
module rom_window_fetch
  import rom_window_fetch_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int K      = K_DEF,
  parameter int STRIDE = 1,
  parameter int FIFO_D = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rom_aa,
  output logic          rom_cena,
  input  logic [WD-1:0] rom_qa,
  output logic [WD-1:0] pix_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_last
);

  localparam int OUT = out_dim(IMG_W, K, STRIDE);
  localparam int CW  = $clog2(FIFO_D + 1);
  localparam logic [AW-1:0] OUT_M1 = AW'(OUT - 1);
  localparam logic [AW-1:0] K_M1   = AW'(K - 1);
  localparam logic [AW-1:0] STR    = AW'(STRIDE);
  localparam logic [AW-1:0] IW     = AW'(IMG_W);

  state_e        state_q;
  logic          busy_q;
  logic          done_q;
  logic          cena_q;
  logic [AW-1:0] aa_q;
  logic [AW-1:0] oy_q;
  logic [AW-1:0] ox_q;
  logic [AW-1:0] ky_q;
  logic [AW-1:0] kx_q;
  logic          last1_q;
  logic          rd2_q;
  logic          last2_q;

  logic [AW-1:0] addr;
  logic [1:0]    inflight;
  logic [CW-1:0] fcnt;
  logic          issue;
  logic          k_end;
  logic          pop;
  logic [WD:0]   fout;

  assign addr     = (oy_q * STR + ky_q) * IW + ox_q * STR + kx_q;
  // stage 1: request registered toward ROM; stage 2: data on rom_qa
  assign inflight = {1'b0, ~cena_q} + {1'b0, rd2_q};
  assign issue    = (state_q == S_RUN)
                 && ((int'(fcnt) + int'(inflight)) < FIFO_D);
  assign k_end    = (kx_q == K_M1) && (ky_q == K_M1);
  assign pop      = pix_valid && pix_ready;

  assign busy      = busy_q;
  assign done      = done_q;
  assign rom_aa    = aa_q;
  assign rom_cena  = cena_q;
  assign pix_valid = (fcnt != '0);
  assign pix_data  = fout[WD-1:0];
  assign pix_last  = fout[WD];

  fetch_fifo #(
    .DW (WD + 1),
    .D  (FIFO_D)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (abort),
    .push_i  (rd2_q),
    .din_i   ({last2_q, rom_qa}),
    .pop_i   (pop),
    .dout_o  (fout),
    .count_o (fcnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cena_q  <= 1'b1;
      aa_q    <= '0;
      oy_q    <= '0;
      ox_q    <= '0;
      ky_q    <= '0;
      kx_q    <= '0;
      last1_q <= 1'b0;
      rd2_q   <= 1'b0;
      last2_q <= 1'b0;
    end else if (abort) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cena_q  <= 1'b1;
      oy_q    <= '0;
      ox_q    <= '0;
      ky_q    <= '0;
      kx_q    <= '0;
      last1_q <= 1'b0;
      rd2_q   <= 1'b0;
      last2_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      cena_q  <= 1'b1;
      rd2_q   <= ~cena_q;
      last2_q <= last1_q;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            oy_q    <= '0;
            ox_q    <= '0;
            ky_q    <= '0;
            kx_q    <= '0;
          end
        end
        S_RUN: begin
          if (issue) begin
            cena_q  <= 1'b0;
            aa_q    <= addr;
            last1_q <= k_end;
            if (kx_q != K_M1) begin
              kx_q <= kx_q + 1'b1;
            end else begin
              kx_q <= '0;
              if (ky_q != K_M1) begin
                ky_q <= ky_q + 1'b1;
              end else begin
                ky_q <= '0;
                if (ox_q != OUT_M1) begin
                  ox_q <= ox_q + 1'b1;
                end else begin
                  ox_q <= '0;
                  if (oy_q != OUT_M1) begin
                    oy_q <= oy_q + 1'b1;
                  end else begin
                    oy_q    <= '0;
                    state_q <= S_DRAIN;
                  end
                end
              end
            end
          end
        end
        S_DRAIN: begin
          if ((fcnt == '0) && (inflight == 2'd0)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_window_fetch.sv
// Scoreboard bench: window-scan model feeds a queue, a monitor pops on
// every accepted pixel; latency, stalls, abort and reset are probed too.
module tb_rom_window_fetch;

  localparam int IMG   = 32;
  localparam int KK    = 5;
  localparam int ST    = 1;
  localparam int FD    = 4;
  localparam int OUT   = (IMG - KK) / ST + 1;
  localparam int TOTAL = OUT * OUT * KK * KK;
  localparam int WINS  = OUT * OUT;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } pix_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic [9:0] rom_aa;
  logic       rom_cena;
  logic [7:0] rom_qa;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic       pix_last;

  logic [7:0] rom [1024];
  pix_t       exp_q [$];
  logic [7:0] log_d [64];
  logic       log_l [64];

  int checks;
  int failures;
  int xfers;
  int lasts;
  int bubbles;
  int done_cnt;
  int max_cnt;
  bit count_bubbles;
  bit prev_stall;
  bit prev_flush;
  logic [7:0] prev_data;
  logic       prev_last;

  rom_window_fetch #(
    .IMG_W  (IMG),
    .K      (KK),
    .STRIDE (ST),
    .FIFO_D (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .rom_aa    (rom_aa),
    .rom_cena  (rom_cena),
    .rom_qa    (rom_qa),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_last  (pix_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int a = 0; a < 1024; a++) rom[a] = 8'(a);
    rom_qa = '0;
  end

  always @(posedge clk) begin
    if (!rom_cena) rom_qa <= rom[rom_aa];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected stream straight from the window/pixel ordering rules.
  task automatic load_model();
    pix_t p;
    int a;
    exp_q.delete();
    for (int oy = 0; oy < OUT; oy++)
      for (int ox = 0; ox < OUT; ox++)
        for (int ky = 0; ky < KK; ky++)
          for (int kx = 0; kx < KK; kx++) begin
            a   = (oy * ST + ky) * IMG + ox * ST + kx;
            p.d = a[7:0];
            p.l = (ky == KK - 1) && (kx == KK - 1);
            exp_q.push_back(p);
          end
  endtask

  always @(negedge clk) begin
    pix_t e;
    if (int'(dut.u_fifo.count_o) > max_cnt) max_cnt = int'(dut.u_fifo.count_o);
    if (prev_stall && !prev_flush) begin
      chk("stall_valid", pix_valid, 1);
      chk("stall_data", pix_data, prev_data);
      chk("stall_last", pix_last, prev_last);
    end
    prev_stall = pix_valid && !pix_ready;
    prev_flush = rst || abort;
    prev_data  = pix_data;
    prev_last  = pix_last;
    if (pix_valid && pix_ready && !rst && !abort) begin
      chk("queue_has_entry", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (pix_data !== e.d || pix_last !== e.l) begin
          checks++;
          failures++;
          $display("FAIL pixel[%0d]: got d=%0h l=%0b expected d=%0h l=%0b",
                   xfers, pix_data, pix_last, e.d, e.l);
        end else begin
          checks++;
        end
      end
      if (xfers < 64) begin
        log_d[xfers] = pix_data;
        log_l[xfers] = pix_last;
      end
      xfers++;
      if (pix_last) lasts++;
    end else if (count_bubbles && xfers > 0 && xfers < TOTAL && !pix_valid) begin
      bubbles++;
    end
    if (done) begin
      done_cnt++;
      chk("done_after_last", exp_q.size(), 0);
    end
  end

  task automatic check_reset_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cena"}, rom_cena, 1);
    chk({tag, "_aa"}, rom_aa, 0);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_last"}, pix_last, 0);
    chk({tag, "_data"}, pix_data, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, input int d0);
    for (int c = 0; c < 60000; c++) begin
      @(posedge clk);
      #1;
      if (rnd) begin
        pix_ready = 1'($urandom_range(0, 1));
        start     = (c == 300);
      end
      if (done_cnt != d0) break;
    end
    start = 1'b0;
  endtask

  task automatic wait_xfers(input int n);
    for (int c = 0; c < 2000 && xfers < n; c++) begin
      @(posedge clk);
      #1;
    end
    chk("xfer_reach", int'(xfers >= n), 1);
  endtask

  initial begin
    int d0;
    int lat;
    checks = 0;
    failures = 0;
    xfers = 0;
    lasts = 0;
    bubbles = 0;
    done_cnt = 0;
    max_cnt = 0;
    count_bubbles = 0;
    prev_stall = 0;
    prev_flush = 1;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full scan, consumer always ready
    load_model();
    xfers = 0;
    lasts = 0;
    bubbles = 0;
    count_bubbles = 1;
    pix_ready = 1'b1;
    d0 = done_cnt;
    pulse_start();
    lat = 0;
    for (int e = 1; e <= 10; e++) begin
      if (pix_valid) begin
        lat = e - 1;
        break;
      end
      @(posedge clk);
      #1;
      if (pix_valid) begin
        lat = e;
        break;
      end
    end
    chk("first_latency", lat, 3);
    wait_done(0, d0);
    count_bubbles = 0;
    chk("s1_done_pulses", done_cnt - d0, 1);
    chk("s1_xfers", xfers, TOTAL);
    chk("s1_lasts", lasts, WINS);
    chk("s1_bubbles", bubbles, 0);
    chk("s1_queue_empty", exp_q.size(), 0);
    chk("px0_data", log_d[0], 8'h00);
    chk("px24_data", log_d[24], 8'h84);
    chk("px24_last", log_l[24], 1);
    chk("px23_last", log_l[23], 0);
    chk("win1_first", log_d[25], 1);
    chk("win1_last", log_d[49], 133);
    @(posedge clk);
    #1 chk("s1_idle_busy", busy, 0);
    chk("s1_done_single", done, 0);

    // Random back-pressure with an ignored start mid-scan
    load_model();
    xfers = 0;
    lasts = 0;
    max_cnt = 0;
    d0 = done_cnt;
    pulse_start();
    wait_done(1, d0);
    pix_ready = 1'b1;
    chk("s2_done_pulses", done_cnt - d0, 1);
    chk("s2_xfers", xfers, TOTAL);
    chk("s2_lasts", lasts, WINS);
    chk("s2_max_fifo_ok", int'(max_cnt <= FD), 1);
    repeat (5) @(posedge clk);
    #1 chk("s2_no_restart_busy", busy, 0);
    chk("s2_no_extra_xfers", xfers, TOTAL);

    // Abort after 100 transfers
    load_model();
    xfers = 0;
    d0 = done_cnt;
    pulse_start();
    wait_xfers(100);
    pix_ready = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_valid", pix_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cena", rom_cena, 1);
    pix_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_stays_idle", pix_valid, 0);

    // Restart from address 0, then reset after 50 transfers
    load_model();
    xfers = 0;
    pulse_start();
    wait_xfers(50);
    chk("restart_px0", log_d[0], 0);
    chk("restart_px49", log_d[49], 133);
    pix_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 check_reset_outs("midrst");
    rst = 1'b0;
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1 chk("post_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
